// File: rtl/dmem_word_arbiter.sv
// Two-port word arbiter that sequences each granted 32-bit access as four big-endian byte accesses.
// Define DMEM_ARB_PRIO_EN for fixed priority (port A wins ties); default is round robin.
module dmem_word_arbiter #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [31:0]       a_wdata,
    output logic              a_ack,
    output logic [31:0]       a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       b_wdata,
    output logic              b_ack,
    output logic [31:0]       b_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [1:0]          k_r, k_s;
    logic                we_r, we_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [31:0]         wdata_r, wdata_s;
    logic [31:0]         rd_buf_r, rd_buf_s;
    logic                last_r, last_s;
    logic                grant_s, tie_pick_s, pick_s;
    logic                a_ack_s, b_ack_s, busy_s;
    logic [31:0]         a_rdata_s, b_rdata_s;
    logic                mem_en_s, mem_we_s;
    logic [ADDR_W-1:0]   mem_addr_s;
    logic [7:0]          mem_wdata_s;

    // Byte idx of a word, byte 0 being the most significant.
    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            2'd3:    b = w[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Tie-break choice between simultaneous requests.
    always_comb begin
`ifdef DMEM_ARB_PRIO_EN
        tie_pick_s = 1'b0;
`else
        tie_pick_s = ~last_r;
`endif
    end

    // Next-state, latched transaction fields and next values of all registered outputs.
    always_comb begin
        state_s     = state_r;
        k_s         = k_r;
        we_s        = we_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        rd_buf_s    = rd_buf_r;
        last_s      = last_r;
        grant_s     = grant;
        pick_s      = 1'b0;
        a_ack_s     = 1'b0;
        b_ack_s     = 1'b0;
        a_rdata_s   = a_rdata;
        b_rdata_s   = b_rdata;
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = '0;
        mem_wdata_s = 8'h00;
        case (state_r)
            IDLE: begin
                if (a_req || b_req) begin
                    if (a_req && b_req) begin
                        pick_s = tie_pick_s;
                    end else begin
                        pick_s = b_req;
                    end
                    grant_s     = pick_s;
                    we_s        = pick_s ? b_we : a_we;
                    addr_s      = pick_s ? b_addr : a_addr;
                    wdata_s     = pick_s ? b_wdata : a_wdata;
                    k_s         = 2'd0;
                    state_s     = XFER;
                    mem_en_s    = 1'b1;
                    mem_we_s    = we_s;
                    mem_addr_s  = addr_s;
                    mem_wdata_s = byte_of(wdata_s, 2'd0);
                end else begin
                    state_s = IDLE;
                end
            end
            XFER: begin
                if (!we_r) begin
                    rd_buf_s = {rd_buf_r[23:0], mem_rdata};
                end else begin
                    rd_buf_s = rd_buf_r;
                end
                if (k_r == 2'd3) begin
                    // Read word is committed to the owner's register as ack rises.
                    if (!we_r && grant) begin
                        b_rdata_s = rd_buf_s;
                    end else if (!we_r) begin
                        a_rdata_s = rd_buf_s;
                    end else begin
                        a_rdata_s = a_rdata;
                    end
                    a_ack_s = ~grant;
                    b_ack_s = grant;
                    state_s = DONE;
                end else begin
                    k_s         = k_r + 2'd1;
                    mem_en_s    = 1'b1;
                    mem_we_s    = we_r;
                    mem_addr_s  = addr_r + ADDR_W'(k_s);
                    mem_wdata_s = byte_of(wdata_r, k_s);
                end
            end
            DONE: begin
                last_s  = grant;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and output registers; async reset aborts any transaction without ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            k_r       <= 2'd0;
            we_r      <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= 32'h0;
            rd_buf_r  <= 32'h0;
            last_r    <= 1'b1;
            grant     <= 1'b0;
            busy      <= 1'b0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_rdata   <= 32'h0;
            b_rdata   <= 32'h0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
        end else begin
            state_r   <= state_s;
            k_r       <= k_s;
            we_r      <= we_s;
            addr_r    <= addr_s;
            wdata_r   <= wdata_s;
            rd_buf_r  <= rd_buf_s;
            last_r    <= last_s;
            grant     <= grant_s;
            busy      <= busy_s;
            a_ack     <= a_ack_s;
            b_ack     <= b_ack_s;
            a_rdata   <= a_rdata_s;
            b_rdata   <= b_rdata_s;
            mem_en    <= mem_en_s;
            mem_we    <= mem_we_s;
            mem_addr  <= mem_addr_s;
            mem_wdata <= mem_wdata_s;
        end
    end

endmodule
